rise_edge_detector: RTL and testbench

//  Per-bit edge detector for single-clock-domain control signals; flags a 0->1 (and 1->0) transition of sig_i.

---
 rtl/rise_edge_detector.sv | 83 ++++++++
 tb/tb_rise_edge_detector.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rise_edge_detector.sv
// Per-lane edge detector: optional input synchroniser, previous-value register and rise/fall/any
// edge pulses that are either combinational or registered.
module rise_edge_detector #(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned SYNC_STAGES = 0,
    parameter int unsigned REG_OUT     = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] sig_i,
    output logic [WIDTH-1:0] sig_o,
    output logic [WIDTH-1:0] fall_o,
    output logic [WIDTH-1:0] edge_o
);

    logic [WIDTH-1:0] sig_s;
    logic [WIDTH-1:0] prev_d, prev_q;
    logic [WIDTH-1:0] rise, fall;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign sig_s = sig_i;
    end else begin : g_sync
        logic [WIDTH-1:0] sync_q [SYNC_STAGES];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                    sync_q[i] <= '0;
                end
            end else begin
                sync_q[0] <= sig_i;
                for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                    sync_q[i] <= sync_q[i-1];
                end
            end
        end

        assign sig_s = sync_q[SYNC_STAGES-1];
    end

    // prev clears on reset, so a lane already high at release reports one rise.
    always_comb begin
        prev_d = sig_s;
        if (rst_i) begin
            prev_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        prev_q <= prev_d;
    end

    always_comb begin
        rise = sig_s & ~prev_q;
        fall = ~sig_s & prev_q;
    end

    if (REG_OUT != 0) begin : g_reg_out
        logic [WIDTH-1:0] rise_q, fall_q, edge_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                rise_q <= '0;
                fall_q <= '0;
                edge_q <= '0;
            end else begin
                rise_q <= rise;
                fall_q <= fall;
                edge_q <= rise | fall;
            end
        end

        assign sig_o  = rise_q;
        assign fall_o = fall_q;
        assign edge_o = edge_q;
    end else begin : g_comb_out
        // Gating by rst_i keeps outputs 0 even if sig_i is X while reset is held.
        assign sig_o  = rst_i ? '0 : rise;
        assign fall_o = rst_i ? '0 : fall;
        assign edge_o = rst_i ? '0 : (rise | fall);
    end

endmodule

// File: tb/tb_rise_edge_detector.sv
// Bench for rise_edge_detector: three configurations (comb, registered, 4-lane with 2-stage sync)
// driven from a vector table and hand sequences, checked through an expected-value queue.
module tb_rise_edge_detector;

    typedef struct {
        logic       rst;
        logic       a;
        logic [3:0] b;
        logic       r0, f0, r1, f1;
        logic [3:0] r2, f2;
    } vec_t;

    typedef struct {
        logic       r0, f0, r1, f1;
        logic [3:0] r2, f2;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       a;
    logic [3:0] b;

    logic       c_rise, c_fall, c_edge;
    logic       r_rise, r_fall, r_edge;
    logic [3:0] s_rise, s_fall, s_edge;

    int total;
    int bad;
    exp_t sb_q[$];
    vec_t vecs[18];

    rise_edge_detector #(.WIDTH(1), .SYNC_STAGES(0), .REG_OUT(0)) u_comb (
        .clk_i (clk),
        .rst_i (rst),
        .sig_i (a),
        .sig_o (c_rise),
        .fall_o(c_fall),
        .edge_o(c_edge)
    );

    rise_edge_detector #(.WIDTH(1), .SYNC_STAGES(0), .REG_OUT(1)) u_reg (
        .clk_i (clk),
        .rst_i (rst),
        .sig_i (a),
        .sig_o (r_rise),
        .fall_o(r_fall),
        .edge_o(r_edge)
    );

    rise_edge_detector #(.WIDTH(4), .SYNC_STAGES(2), .REG_OUT(0)) u_sync (
        .clk_i (clk),
        .rst_i (rst),
        .sig_i (b),
        .sig_o (s_rise),
        .fall_o(s_fall),
        .edge_o(s_edge)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic rst_v, input logic a_v, input logic [3:0] b_v,
                                input logic r0, input logic f0, input logic r1, input logic f1,
                                input logic [3:0] r2, input logic [3:0] f2);
        vec_t v;
        v.rst = rst_v; v.a = a_v; v.b = b_v;
        v.r0 = r0; v.f0 = f0; v.r1 = r1; v.f1 = f1; v.r2 = r2; v.f2 = f2;
        return v;
    endfunction

    task automatic push(input logic r0, input logic f0, input logic r1, input logic f1,
                        input logic [3:0] r2, input logic [3:0] f2);
        exp_t e;
        e.r0 = r0; e.f0 = f0; e.r1 = r1; e.f1 = f1; e.r2 = r2; e.f2 = f2;
        sb_q.push_back(e);
    endtask

    task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty, got nothing want an entry", tag);
            return;
        end
        e = sb_q.pop_front();
        cmp({tag, ".comb_rise"}, {3'b0, c_rise}, {3'b0, e.r0});
        cmp({tag, ".comb_fall"}, {3'b0, c_fall}, {3'b0, e.f0});
        cmp({tag, ".comb_edge"}, {3'b0, c_edge}, {3'b0, e.r0 | e.f0});
        cmp({tag, ".reg_rise"},  {3'b0, r_rise}, {3'b0, e.r1});
        cmp({tag, ".reg_fall"},  {3'b0, r_fall}, {3'b0, e.f1});
        cmp({tag, ".reg_edge"},  {3'b0, r_edge}, {3'b0, e.r1 | e.f1});
        cmp({tag, ".sync_rise"}, s_rise, e.r2);
        cmp({tag, ".sync_fall"}, s_fall, e.f2);
        cmp({tag, ".sync_edge"}, s_edge, e.r2 | e.f2);
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // rst a b | comb r f | reg r f | sync r f
        vecs[0]  = mk(1, 0, 4'h0,  0, 0,  0, 0,  4'h0, 4'h0);
        vecs[1]  = mk(0, 0, 4'h0,  0, 0,  0, 0,  4'h0, 4'h0);
        vecs[2]  = mk(0, 1, 4'h0,  1, 0,  0, 0,  4'h0, 4'h0);
        vecs[3]  = mk(0, 1, 4'hA,  0, 0,  1, 0,  4'h0, 4'h0);
        vecs[4]  = mk(0, 0, 4'hA,  0, 1,  0, 0,  4'h0, 4'h0);
        vecs[5]  = mk(0, 0, 4'hA,  0, 0,  0, 1,  4'hA, 4'h0);
        vecs[6]  = mk(0, 0, 4'h0,  0, 0,  0, 0,  4'h0, 4'h0);
        vecs[7]  = mk(0, 0, 4'h0,  0, 0,  0, 0,  4'h0, 4'h0);
        vecs[8]  = mk(0, 0, 4'h0,  0, 0,  0, 0,  4'h0, 4'hA);
        vecs[9]  = mk(0, 0, 4'h5,  0, 0,  0, 0,  4'h0, 4'h0);
        vecs[10] = mk(0, 0, 4'hF,  0, 0,  0, 0,  4'h0, 4'h0);
        vecs[11] = mk(1, 1, 4'hF,  0, 0,  0, 0,  4'h0, 4'h0);
        vecs[12] = mk(0, 1, 4'hF,  1, 0,  0, 0,  4'h0, 4'h0);
        vecs[13] = mk(0, 1, 4'hF,  0, 0,  1, 0,  4'h0, 4'h0);
        vecs[14] = mk(0, 1, 4'hF,  0, 0,  0, 0,  4'hF, 4'h0);
        vecs[15] = mk(0, 1, 4'h0,  0, 0,  0, 0,  4'h0, 4'h0);
        vecs[16] = mk(0, 0, 4'h0,  0, 1,  0, 0,  4'h0, 4'h0);
        vecs[17] = mk(0, 0, 4'h0,  0, 0,  0, 1,  4'h0, 4'hF);

        // X inputs while in reset must not leak once reset has been applied.
        rst = 1'b1;
        a   = 1'bx;
        b   = 4'bxxxx;
        repeat (3) @(posedge clk);

        for (int k = 0; k < 18; k++) begin
            @(posedge clk);
            #1;
            rst = vecs[k].rst;
            a   = vecs[k].a;
            b   = vecs[k].b;
            push(vecs[k].r0, vecs[k].f0, vecs[k].r1, vecs[k].f1, vecs[k].r2, vecs[k].f2);
            #4;
            check($sformatf("vec%0d", k));
        end

        // Glitch between edges: comb output follows, nothing is sampled.
        @(posedge clk);
        #1 a = 1'b1;
        push(1, 0, 0, 0, 4'h0, 4'h0);
        #2 check("glitch_hi");
        #2 a = 1'b0;
        push(0, 0, 0, 0, 4'h0, 4'h0);
        #2 check("glitch_lo");
        @(posedge clk);
        push(0, 0, 0, 0, 4'h0, 4'h0);
        #5 check("glitch_after");

        // Held level: one pulse per configuration, then silence.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            a = 1'b1;
            b = 4'b0110;
            push(i == 0, 0, i == 1, 0, (i == 2) ? 4'b0110 : 4'h0, 4'h0);
            #4;
            check($sformatf("hold%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
